// File: rtl/vc_iter_divider_pkg.sv
// Shared definitions for the iterative divider: FSM state and operation-mode encodings.
package vc_iter_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      FN_UNSIGNED = 1'b0,
      FN_SIGNED   = 1'b1
   } fn_t;

endpackage

// File: rtl/vc_iter_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor, and keep the difference only when it did not underflow.
module vc_iter_divider_div_step
#(
   parameter int unsigned W = 32
)
(
   input  logic [W-1:0] rem_in,
   input  logic         bit_in,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_out,
   output logic         q_bit
);

   logic [W:0]   shifted;
   logic [W-1:0] trial;

   // The true difference is below the divisor, so W-bit modular subtraction is exact.
   always_comb begin
      shifted = {rem_in, bit_in};
      q_bit   = (shifted >= {1'b0, divisor});
      trial   = shifted[W-1:0] - divisor;
      rem_out = q_bit ? trial : shifted[W-1:0];
   end

endmodule

// File: rtl/vc_iter_divider.sv
// Iterative W-bit divider, one quotient bit per cycle, signed/unsigned, with
// valid/ready handshakes on both request and result sides.
module vc_iter_divider
   import vc_iter_divider_pkg::*;
#(
   parameter int unsigned W = 32
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic         in_val,
   output logic         in_rdy,
   input  logic         in_fn,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_val,
   input  logic         out_rdy,
   output logic [W-1:0] out_quot,
   output logic [W-1:0] out_rem
);

   localparam int unsigned CW = $clog2(W + 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [W-1:0]  acc, qa, dvsr;
   logic          neg_q, neg_r, dbz;
   logic [W-1:0]  step_rem;
   logic          step_q;

   logic          accept, calc_bit, finish;
   logic          is_signed, a_neg, b_neg;
   logic [W-1:0]  a_mag, b_mag;

   always_comb begin
      accept    = (state == IDLE) && in_val;
      calc_bit  = (state == CALC) && (cnt != '0);
      finish    = (state == CALC) && (cnt == '0);
      is_signed = (fn_t'(in_fn) == FN_SIGNED);
      a_neg     = is_signed && in_a[W-1];
      b_neg     = is_signed && in_b[W-1];
      a_mag     = a_neg ? -in_a : in_a;
      b_mag     = b_neg ? -in_b : in_b;
   end

   vc_iter_divider_div_step #(
      .W (W)
   ) u_step (
      .rem_in  (acc),
      .bit_in  (qa[W-1]),
      .divisor (dvsr),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_val)  state_nxt = CALC;
         CALC:    if (finish)  state_nxt = DONE;
         DONE:    if (out_rdy) state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_rdy  = (state == IDLE);
      out_val = (state == DONE);
   end

   // qa starts as the dividend magnitude and fills with quotient bits as it shifts out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         acc   <= '0;
         qa    <= '0;
         dvsr  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dbz   <= 1'b0;
      end else if (accept) begin
         cnt   <= CW'(W);
         acc   <= '0;
         qa    <= a_mag;
         dvsr  <= b_mag;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
         dbz   <= (in_b == '0);
      end else if (calc_bit) begin
         cnt   <= cnt - CW'(1);
         acc   <= step_rem;
         qa    <= {qa[W-2:0], step_q};
      end
   end

   // Divide-by-zero leaves |a| in acc, so the normal remainder fix-up already yields in_a.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_quot <= '0;
         out_rem  <= '0;
      end else if (finish) begin
         out_quot <= dbz ? '1 : (neg_q ? -qa : qa);
         out_rem  <= neg_r ? -acc : acc;
      end
   end

endmodule

// File: tb/tb_vc_iter_divider.sv
// Self-checking bench for vc_iter_divider at W=8: directed corner cases plus
// randomized operations checked against an arithmetic reference model.
module tb_vc_iter_divider;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_val = 1'b0;
   logic         in_rdy;
   logic         in_fn = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_val;
   logic         out_rdy = 1'b0;
   logic [W-1:0] out_quot;
   logic [W-1:0] out_rem;

   int checks = 0;
   int errors = 0;

   vc_iter_divider #(
      .W (W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_val   (in_val),
      .in_rdy   (in_rdy),
      .in_fn    (in_fn),
      .in_a     (in_a),
      .in_b     (in_b),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out_quot (out_quot),
      .out_rem  (out_rem)
   );

   always #5 clk = ~clk;

   // Reference: truncating division on integers, with the fixed div-by-zero and overflow results.
   function automatic void ref_div(input logic fn, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
      int sa, sb;
      if (b == 0) begin
         q = 8'hFF;
         r = a;
      end else if (!fn) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = $signed(a);
         sb = $signed(b);
         if (sa == -128 && sb == -1) begin
            q = a;
            r = 8'h00;
         end else begin
            q = 8'(sa / sb);
            r = 8'(sa % sb);
         end
      end
   endfunction

   task automatic accept_req(input logic fn, input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned n = 0;
      while (!in_rdy && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_rdy !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait in_rdy=%b expected 1", in_rdy);
      end
      in_fn  = fn;
      in_a   = a;
      in_b   = b;
      in_val = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_val = 1'b0;
   endtask

   task automatic wait_out(output int unsigned lat);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_val === 1'b1) break;
      end
   endtask

   task automatic release_out();
      out_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_rdy = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #2;
      checks++;
      if ({in_rdy, out_val, out_quot, out_rem} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
         errors++;
         $display("FAIL reset_state rdy=%b val=%b q=%h r=%h expected rdy=1 val=0 q=00 r=00",
                  in_rdy, out_val, out_quot, out_rem);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks++;
      if (in_rdy !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_rdy in_rdy=%b expected 1", in_rdy);
      end
   endtask

   typedef struct {
      logic         fn;
      logic [W-1:0] a, b, q, r;
   } vec_t;

   task automatic test_directed();
      vec_t vecs[6];
      int unsigned lat;
      vecs[0] = '{1'b0, 8'd100, 8'd7,  8'h0E, 8'h02};
      vecs[1] = '{1'b1, 8'hF9,  8'h02, 8'hFD, 8'hFF};
      vecs[2] = '{1'b1, 8'h07,  8'hFE, 8'hFD, 8'h01};
      vecs[3] = '{1'b0, 8'h2A,  8'h00, 8'hFF, 8'h2A};
      vecs[4] = '{1'b1, 8'h2A,  8'h00, 8'hFF, 8'h2A};
      vecs[5] = '{1'b1, 8'h80,  8'hFF, 8'h80, 8'h00};
      foreach (vecs[i]) begin
         accept_req(vecs[i].fn, vecs[i].a, vecs[i].b);
         wait_out(lat);
         checks++;
         if (lat !== 9) begin
            errors++;
            $display("FAIL dir%0d_latency got=%0d expected 9", i, lat);
         end
         checks++;
         if (out_quot !== vecs[i].q) begin
            errors++;
            $display("FAIL dir%0d_quot got=%h expected %h", i, out_quot, vecs[i].q);
         end
         checks++;
         if (out_rem !== vecs[i].r) begin
            errors++;
            $display("FAIL dir%0d_rem got=%h expected %h", i, out_rem, vecs[i].r);
         end
         release_out();
      end
   endtask

   task automatic test_backpressure();
      int unsigned lat;
      accept_req(1'b0, 8'd100, 8'd7);
      in_val = 1'b1;
      in_a   = 8'd3;
      in_b   = 8'd1;
      wait_out(lat);
      checks++;
      if (lat !== 9 || out_quot !== 8'h0E || out_rem !== 8'h02) begin
         errors++;
         $display("FAIL bp_result lat=%0d q=%h r=%h expected lat=9 q=0e r=02", lat, out_quot, out_rem);
      end
      for (int i = 0; i < 5; i++) begin
         in_val = ~in_val;
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({out_val, in_rdy, out_quot, out_rem} !== {1'b1, 1'b0, 8'h0E, 8'h02}) begin
            errors++;
            $display("FAIL bp_hold%0d val=%b rdy=%b q=%h r=%h expected val=1 rdy=0 q=0e r=02",
                     i, out_val, in_rdy, out_quot, out_rem);
         end
      end
      in_val = 1'b0;
      release_out();
      repeat (3) @(negedge clk);
      checks++;
      if ({out_val, in_rdy, out_quot, out_rem} !== {1'b0, 1'b1, 8'h0E, 8'h02}) begin
         errors++;
         $display("FAIL bp_idle_hold val=%b rdy=%b q=%h r=%h expected val=0 rdy=1 q=0e r=02",
                  out_val, in_rdy, out_quot, out_rem);
      end
   endtask

   task automatic test_reset_mid_calc();
      int unsigned lat;
      logic seen;
      accept_req(1'b0, 8'd100, 8'd7);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({out_val, in_rdy, out_quot, out_rem} !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
         errors++;
         $display("FAIL midreset_async val=%b rdy=%b q=%h r=%h expected val=0 rdy=1 q=00 r=00",
                  out_val, in_rdy, out_quot, out_rem);
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (14) begin
         @(negedge clk);
         if (out_val !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL midreset_discard out_val_seen=%b expected 0", seen);
      end
      accept_req(1'b0, 8'd200, 8'd10);
      wait_out(lat);
      checks++;
      if (lat !== 9 || out_quot !== 8'd20 || out_rem !== 8'd0) begin
         errors++;
         $display("FAIL midreset_next lat=%0d q=%h r=%h expected lat=9 q=14 r=00", lat, out_quot, out_rem);
      end
      release_out();
   endtask

   task automatic test_back_to_back();
      int unsigned lat;
      logic         fn;
      logic [W-1:0] a, b, eq, er;
      out_rdy = 1'b1;
      for (int k = 0; k < 6; k++) begin
         fn = 1'($urandom);
         a  = 8'($urandom);
         b  = 8'($urandom_range(1, 255));
         ref_div(fn, a, b, eq, er);
         accept_req(fn, a, b);
         in_val = 1'b1;
         in_a   = 8'($urandom);
         in_b   = 8'($urandom);
         wait_out(lat);
         checks++;
         if (lat !== 9 || out_quot !== eq || out_rem !== er) begin
            errors++;
            $display("FAIL b2b%0d lat=%0d q=%h r=%h expected lat=9 q=%h r=%h", k, lat, out_quot, out_rem, eq, er);
         end
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({in_rdy, out_val} !== 2'b10) begin
            errors++;
            $display("FAIL b2b%0d_no_bypass rdy=%b val=%b expected rdy=1 val=0", k, in_rdy, out_val);
         end
      end
      in_val  = 1'b0;
      out_rdy = 1'b0;
   endtask

   task automatic test_random();
      int unsigned lat;
      logic         fn;
      logic [W-1:0] a, b, eq, er, ident;
      for (int k = 0; k < 40; k++) begin
         fn = 1'($urandom);
         a  = 8'($urandom);
         case ($urandom_range(0, 7))
            0:       b = 8'h00;
            1:       b = 8'hFF;
            2:       begin b = 8'hFF; a = 8'h80; end
            default: b = 8'($urandom);
         endcase
         ref_div(fn, a, b, eq, er);
         accept_req(fn, a, b);
         wait_out(lat);
         checks++;
         if (lat !== 9 || out_quot !== eq || out_rem !== er) begin
            errors++;
            $display("FAIL rnd%0d fn=%b a=%h b=%h lat=%0d q=%h r=%h expected lat=9 q=%h r=%h",
                     k, fn, a, b, lat, out_quot, out_rem, eq, er);
         end
         if (b != 0) begin
            ident = out_quot * b + out_rem;
            checks++;
            if (ident !== a) begin
               errors++;
               $display("FAIL rnd%0d_identity q*b+r=%h expected %h", k, ident, a);
            end
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         release_out();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_calc();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vc_iter_divider.md
VC_ITER_DIVIDER -- requirements
Module: vcIterDivider

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand/result width (W >= 2).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_val  input  1  request valid.
REQ-005 SHALL have port in_rdy  output  1  block can accept a request.
REQ-006 SHALL have port in_fn  input  1  0 = unsigned, 1 = signed (two's complement).
REQ-007 SHALL have port in_a  input  W  dividend.
REQ-008 SHALL have port in_b  input  W  divisor.
REQ-009 SHALL have port out_val  output  1  result valid.
REQ-010 SHALL have port out_rdy  input  1  consumer accepts result.
REQ-011 SHALL have port out_quot  output  W  quotient.
REQ-012 SHALL have port out_rem  output  W  remainder.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL drive in_rdy = 1 only in IDLE and out_val = 1 only in DONE; both are pure functions of state.
REQ-015 SHALL accept a request on a rising edge with in_val & in_rdy, latching in_fn, in_a and in_b, and move IDLE -> CALC.
REQ-016 SHALL perform restoring division on operand magnitudes, one quotient bit per cycle, using a counter of clog2(W+1) bits that runs for exactly W CALC cycles.
REQ-017 SHALL move CALC -> DONE on the edge that completes bit 0, so out_val rises exactly W+1 edges after the accept edge.
REQ-018 SHALL apply sign fix-up in signed mode: negate the quotient when the operand signs differ; give the remainder the dividend's sign.
REQ-019 SHALL satisfy in_a = quot*in_b + rem (mod 2^W) for every nonzero divisor.
REQ-020 SHALL return quot = all ones and rem = in_a for divisor 0 in both modes, with unchanged latency.
REQ-021 SHALL return quot = in_a (most negative value) and rem = 0 for signed most-negative / -1, without error.
REQ-022 SHALL hold out_quot and out_rem stable in DONE until out_val & out_rdy, then move DONE -> IDLE.
REQ-023 SHALL NOT accept a new request in the DONE->IDLE transition cycle; in_rdy rises the following cycle (no bypass).
REQ-024 SHALL ignore in_val while in CALC or DONE, and ignore out_rdy outside DONE.
REQ-025 SHALL keep out_quot/out_rem at the last delivered result while in IDLE.

Reset
REQ-026 SHALL on reset, asynchronously and at any time (including mid-CALC or DONE), force state IDLE, counter 0, out_quot 0, out_rem 0, out_val 0, in_rdy 1.
REQ-027 SHALL discard any in-flight operation on reset and never emit its result.
REQ-028 SHALL accept a new request on the first rising edge after reset deasserts.

Structure
REQ-029 SHALL place the FSM state encodings (IDLE=0, CALC=1, DONE=2, 2-bit) and the fn encodings in a shared definitions include, vcIterDividerDefs.
REQ-030 SHALL instantiate one sub-module, vcDivStep: a combinational W+1-bit shift/trial-subtract/restore step producing the next partial remainder and quotient bit.
REQ-031 SHALL keep datapath registers (remainder, quotient/dividend shift, divisor, sign flags, div-by-zero flag) in the top module; target 120-400 lines total.

Verification (W = 8)
REQ-032 SHALL cover unsigned a=100, b=7 -> quot=14 (0x0E), rem=2, out_val exactly 9 edges after accept.
REQ-033 SHALL cover signed a=0xF9 (-7), b=2 -> quot=0xFD (-3), rem=0xFF (-1); and a=7, b=0xFE -> quot=0xFD, rem=0x01.
REQ-034 SHALL cover divide-by-zero a=0x2A, b=0 in both modes -> quot=0xFF, rem=0x2A, latency 9.
REQ-035 SHALL cover signed a=0x80, b=0xFF -> quot=0x80, rem=0x00.
REQ-036 SHALL cover out_rdy held low 5 cycles in DONE -> out_val and results stable, in_rdy=0; in_val pulses during CALC/DONE ignored.
REQ-037 SHALL cover reset asserted mid-CALC (cycle 4) -> out_val=0, in_rdy=1 immediately; next request a=200, b=10 -> quot=20, rem=0.
